mrd_tag_issuer: RTL and testbench
=================================

# mrd_tag_issuer

Downstream stage of the AR header maker. It pops 128-bit memory-read TLP headers from the AR header FIFO and assigns each one a free PCIe tag from a 2^TAG_WIDTH pool, writing the tag into the header. It presents the tagged header to the TLP transmit mux on a valid/ready handshake and reports every issued tag to the completion engine. A tag stays busy until the completion engine releases it.

## Interface
- TAG_WIDTH, 5, tag index width; pool size NTAG = 2^TAG_WIDTH (32)
- HDR_WIDTH, 128, TLP header width; DW0 = bits [31:0], DW1 = bits [63:32]
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- ar_fifo_empty  in  1  AR header FIFO empty
- ar_fifo_rden  out  1  pop strobe; FIFO is non-FWFT, so data is valid the cycle after rden
- ar_fifo_rdata  in  HDR_WIDTH  popped header
- tlp_hdr_valid  out  1  tagged header valid to TX mux
- tlp_hdr_ready  in  1  TX mux accepts
- tlp_hdr  out  HDR_WIDTH  tagged header
- tag_free_valid  in  1  completion engine releases a tag
- tag_free  in  TAG_WIDTH  tag being released
- tag_alloc_valid  out  1  one-cycle pulse when a header is accepted downstream
- tag_alloc  out  TAG_WIDTH  tag of that header
- tag_alloc_len  out  10  DW length field, header bits [9:0]
- outstanding  out  TAG_WIDTH+1  number of busy tags, 0..NTAG
- tag_err  out  1  sticky; set when a release names a non-busy tag

## Operation
- busy[NTAG-1:0] marks reserved tags. The free tag is the lowest index with busy = 0, found by a priority encoder on the registered busy vector. tag_avail = the OR of ~busy.
- FSM states:
  - IDLE: ar_fifo_rden = !ar_fifo_empty && tag_avail (combinational). If rden is high: reserve the encoded tag (busy set, outstanding +1), latch it in cur_tag, go to LOAD.
  - LOAD: capture ar_fifo_rdata into the header register. Overwrite bits [47:40] (the DW1 tag byte) with zero-extended cur_tag. All other bits pass unchanged. Go to SEND.
  - SEND: tlp_hdr_valid = 1. On tlp_hdr_ready:
    - pulse tag_alloc_valid, with tag_alloc = cur_tag and tag_alloc_len = tlp_hdr[9:0];
    - if !ar_fifo_empty && tag_avail, assert rden in this same cycle, reserve the next tag and go to LOAD; otherwise go to IDLE.
- Release: tag_free_valid with busy[tag_free] = 1 clears that busy bit and decrements outstanding. If busy[tag_free] = 0, the release is ignored and tag_err is set; it stays set until rst.
- Simultaneous reserve and release: both take effect in the same cycle. The net change to outstanding is 0. The released tag becomes allocatable the next cycle; the encoder never sees a same-cycle release.
- A release of the tag currently held in LOAD/SEND is legal: the bit is cleared. Sending that header is a completion-engine protocol violation and is not checked here.
- Pool exhausted (outstanding = NTAG): rden stays 0 and the FIFO is not popped. Issue resumes in the cycle after a release.
- Reset mid-operation: any header held in LOAD/SEND is discarded, and that FIFO entry is lost. The upstream path must be reset together with this block.

## Timing
- Reset values:
  - state = IDLE, busy = 0, outstanding = 0, tag_err = 0, cur_tag = 0;
  - ar_fifo_rden = 0, tlp_hdr_valid = 0, tlp_hdr = 0;
  - tag_alloc_valid = 0, tag_alloc = 0, tag_alloc_len = 0.
- Latency: from a cycle with rden = 1, tlp_hdr_valid rises 2 cycles later (rden, LOAD, SEND).
- Throughput: one header per 2 cycles when tlp_hdr_ready is held high, because rden overlaps the SEND handshake.
- While tlp_hdr_valid = 1 and ready = 0, tlp_hdr is held stable; valid never drops without a handshake.
- tag_alloc_valid, tag_alloc and tag_alloc_len are registered. They are valid the cycle after the handshake and the pulse lasts 1 cycle.
- outstanding and tag_err are registered and update the cycle after the triggering event.

## Test plan
- Single header:
  - Stimulus: FIFO holds header 0x…0000_0000_0000_0008 (length 8), ready held at 1.
  - Response: rden pulses once; 2 cycles later tlp_hdr = input with bits [47:40] = 0x00; tag_alloc = 0, tag_alloc_len = 8; outstanding = 1.
- Exhaustion:
  - Stimulus: 33 headers queued, no releases.
  - Response: tags 0..31 issued in order; outstanding = 32; the 33rd header is never popped (rden stays 0).
  - Then: release tag 7 → the 33rd header is popped the next cycle and issued with tag 7.
- Backpressure:
  - Stimulus: ready held low for 10 cycles in SEND.
  - Response: valid = 1 and tlp_hdr unchanged for all 10 cycles; no tag_alloc_valid; exactly one pulse after ready rises.
- Simultaneous:
  - Stimulus: with outstanding = 31 (only tag 31 free), release tag 3 in the same cycle that tag 31 is reserved.
  - Response: outstanding stays 31; the next header gets tag 3.
- Bad release:
  - Stimulus: tag_free_valid with tag 12 while busy[12] = 0.
  - Response: tag_err = 1 (sticky); outstanding unchanged.
- Reset mid-send:
  - Stimulus: rst asserted during SEND.
  - Response: next cycle valid = 0, outstanding = 0, tag_err = 0; the next header is issued with tag 0.

Source files
------------

// File: rtl/mrd_tag_issuer_if.sv
// ---------------------------------------------------------------------------
// mrd_tag_issuer_if
// Groups every bus the tag issuer talks to: the AR header FIFO read side, the
// tagged-header handshake towards the TLP transmit mux, and the tag
// release/allocation channels shared with the completion engine.
//
// Signals:
//   ar_fifo_empty  : AR header FIFO empty (FIFO -> issuer)
//   ar_fifo_rden   : pop strobe, data arrives the following cycle (issuer -> FIFO)
//   ar_fifo_rdata  : popped header (FIFO -> issuer)
//   tlp_hdr_valid  : tagged header valid (issuer -> TX mux)
//   tlp_hdr_ready  : TX mux accepts (TX mux -> issuer)
//   tlp_hdr        : tagged header (issuer -> TX mux)
//   tag_free_valid : completion engine releases a tag
//   tag_free       : tag being released
//   tag_alloc_valid: one-cycle pulse per header accepted downstream
//   tag_alloc      : tag of that header
//   tag_alloc_len  : DW length field of that header
//
// Modports: master = the tag issuer, slave = the surrounding environment.
// ---------------------------------------------------------------------------
interface mrd_tag_issuer_if #(
   parameter int TAG_WIDTH = 5,
   parameter int HDR_WIDTH = 128
);
   logic                 ar_fifo_empty;
   logic                 ar_fifo_rden;
   logic [HDR_WIDTH-1:0] ar_fifo_rdata;
   logic                 tlp_hdr_valid;
   logic                 tlp_hdr_ready;
   logic [HDR_WIDTH-1:0] tlp_hdr;
   logic                 tag_free_valid;
   logic [TAG_WIDTH-1:0] tag_free;
   logic                 tag_alloc_valid;
   logic [TAG_WIDTH-1:0] tag_alloc;
   logic [9:0]           tag_alloc_len;

   modport master (
      input  ar_fifo_empty, ar_fifo_rdata, tlp_hdr_ready, tag_free_valid, tag_free,
      output ar_fifo_rden, tlp_hdr_valid, tlp_hdr, tag_alloc_valid, tag_alloc, tag_alloc_len
   );

   modport slave (
      output ar_fifo_empty, ar_fifo_rdata, tlp_hdr_ready, tag_free_valid, tag_free,
      input  ar_fifo_rden, tlp_hdr_valid, tlp_hdr, tag_alloc_valid, tag_alloc, tag_alloc_len
   );
endinterface

// File: rtl/mrd_tag_issuer.sv
// ---------------------------------------------------------------------------
// mrd_tag_issuer
// Pops memory-read TLP headers from the (non-FWFT) AR header FIFO, stamps each
// with the lowest free PCIe tag from a 2^TAG_WIDTH pool (DW1 tag byte, bits
// [47:40]) and offers it to the TX mux on valid/ready. Every accepted header is
// reported to the completion engine, which later releases the tag.
//
// Ports:
//   i_clk          : sole clock, posedge
//   i_rst          : synchronous active-high reset
//   io_bus         : mrd_tag_issuer_if.master (FIFO, TX mux, tag channels)
//   o_outstanding  : number of busy tags, 0..2^TAG_WIDTH
//   o_tag_err      : sticky flag, a release named a tag that was not busy
// ---------------------------------------------------------------------------
module mrd_tag_issuer #(
   parameter int TAG_WIDTH = 5,
   parameter int HDR_WIDTH = 128
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   mrd_tag_issuer_if.master      io_bus,
   output logic [TAG_WIDTH:0]    o_outstanding,
   output logic                  o_tag_err
);

   localparam int NTAG = 1 << TAG_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [NTAG-1:0]       r_busy;
   logic [NTAG-1:0]       w_busyNext;
   logic [TAG_WIDTH-1:0]  r_curTag;
   logic [TAG_WIDTH-1:0]  w_freeTag;
   logic                  w_tagAvail;
   logic                  w_canIssue;
   logic                  w_rden;
   logic                  w_handshake;
   logic                  w_releaseOk;
   logic                  w_releaseBad;
   logic [HDR_WIDTH-1:0]  r_hdr;
   logic [HDR_WIDTH-1:0]  w_taggedHdr;
   logic                  r_allocValid;
   logic [TAG_WIDTH-1:0]  r_allocTag;
   logic [9:0]            r_allocLen;
   logic [TAG_WIDTH:0]    r_outstanding;
   logic                  r_tagErr;

   // Lowest-index free tag. Scanning downward lets the last hit (lowest index)
   // win. Works on the registered busy vector, so a same-cycle release is not
   // visible until the next cycle.
   always_comb begin
      w_freeTag = '0;
      for (int i = NTAG - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_freeTag = TAG_WIDTH'(i);
         end
      end
   end

   assign w_tagAvail   = ~&r_busy;
   assign w_canIssue   = !io_bus.ar_fifo_empty && w_tagAvail;
   assign w_releaseOk  = io_bus.tag_free_valid &&  r_busy[io_bus.tag_free];
   assign w_releaseBad = io_bus.tag_free_valid && !r_busy[io_bus.tag_free];

   // Next-state and pop logic. The pop in SEND overlaps the downstream
   // handshake so a continuously ready TX mux sees one header every 2 cycles.
   always_comb begin
      w_nextState = r_state;
      w_rden      = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_canIssue) begin
               w_rden      = 1'b1;
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            w_nextState = SEND;
         end
         SEND: begin
            if (io_bus.tlp_hdr_ready) begin
               w_handshake = 1'b1;
               if (w_canIssue) begin
                  w_rden      = 1'b1;
                  w_nextState = LOAD;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A reserve always targets a clear bit and a legal release always targets a
   // set bit, so both can be applied to the same vector without conflict.
   always_comb begin
      w_busyNext = r_busy;
      if (w_releaseOk) begin
         w_busyNext[io_bus.tag_free] = 1'b0;
      end
      if (w_rden) begin
         w_busyNext[w_freeTag] = 1'b1;
      end
   end

   // Pool bookkeeping: busy bits, busy count and the sticky bad-release flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy        <= '0;
         r_outstanding <= '0;
         r_tagErr      <= 1'b0;
      end else begin
         r_busy <= w_busyNext;
         case ({w_rden, w_releaseOk})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
         r_tagErr <= r_tagErr | w_releaseBad;
      end
   end

   // The FIFO delivers data one cycle after the pop, which is the LOAD cycle.
   assign w_taggedHdr = {io_bus.ar_fifo_rdata[HDR_WIDTH-1:48],
                         8'(r_curTag),
                         io_bus.ar_fifo_rdata[39:0]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_curTag <= '0;
         r_hdr    <= '0;
      end else begin
         if (w_rden) begin
            r_curTag <= w_freeTag;
         end
         if (r_state == LOAD) begin
            r_hdr <= w_taggedHdr;
         end
      end
   end

   // Allocation report: one registered pulse per accepted header; tag and
   // length hold their last value between pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_allocValid <= 1'b0;
         r_allocTag   <= '0;
         r_allocLen   <= '0;
      end else begin
         r_allocValid <= w_handshake;
         if (w_handshake) begin
            r_allocTag <= r_curTag;
            r_allocLen <= r_hdr[9:0];
         end
      end
   end

   assign io_bus.ar_fifo_rden    = w_rden;
   assign io_bus.tlp_hdr_valid   = (r_state == SEND);
   assign io_bus.tlp_hdr         = r_hdr;
   assign io_bus.tag_alloc_valid = r_allocValid;
   assign io_bus.tag_alloc       = r_allocTag;
   assign io_bus.tag_alloc_len   = r_allocLen;
   assign o_outstanding          = r_outstanding;
   assign o_tag_err              = r_tagErr;

endmodule

// File: tb/tb_mrd_tag_issuer.sv
// ---------------------------------------------------------------------------
// tb_mrd_tag_issuer
// Directed bench for mrd_tag_issuer. A small non-FWFT FIFO model feeds
// headers; a recorder logs every allocation report and every accepted header.
// Inputs are driven on the falling edge, outputs are sampled on it.
// ---------------------------------------------------------------------------
module tb_mrd_tag_issuer;

   localparam int TW = 5;
   localparam int HW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic [TW:0]   outstanding;
   logic          tagErr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mrd_tag_issuer_if #(.TAG_WIDTH(TW), .HDR_WIDTH(HW)) bus ();

   mrd_tag_issuer #(.TAG_WIDTH(TW), .HDR_WIDTH(HW)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .io_bus        (bus),
      .o_outstanding (outstanding),
      .o_tag_err     (tagErr)
   );

   // Non-FWFT FIFO model: data appears the cycle after the pop.
   logic [HW-1:0] fifoMem [0:63];
   int wrPtr = 0;
   int rdPtr = 0;

   assign bus.ar_fifo_empty = (wrPtr == rdPtr);

   always @(posedge clk) begin
      if (bus.ar_fifo_rden === 1'b1) begin
         bus.ar_fifo_rdata <= fifoMem[rdPtr[5:0]];
         rdPtr <= rdPtr + 1;
      end
   end

   // Recorder of allocation reports, pops and accepted headers.
   logic [TW-1:0] allocTag [0:127];
   logic [9:0]    allocLen [0:127];
   logic [HW-1:0] sentHdr  [0:127];
   int allocCount = 0;
   int rdenCount  = 0;
   int sentCount  = 0;

   always @(posedge clk) begin
      if (bus.tag_alloc_valid === 1'b1) begin
         allocTag[allocCount[6:0]] <= bus.tag_alloc;
         allocLen[allocCount[6:0]] <= bus.tag_alloc_len;
         allocCount <= allocCount + 1;
      end
      if (bus.ar_fifo_rden === 1'b1) begin
         rdenCount <= rdenCount + 1;
      end
      if (bus.tlp_hdr_valid === 1'b1 && bus.tlp_hdr_ready === 1'b1) begin
         sentHdr[sentCount[6:0]] <= bus.tlp_hdr;
         sentCount <= sentCount + 1;
      end
   end

   function automatic logic [HW-1:0] mkHdr(input int k);
      logic [7:0] kb;
      logic [9:0] len;
      kb  = 8'(k);
      len = 10'(k + 1);
      return {kb, 24'hC0FFEE, 32'h0BAD_F00D, 32'h9876_FF54, 22'h0, len};
   endfunction

   function automatic logic [HW-1:0] expHdr(input logic [HW-1:0] h, input logic [TW-1:0] t);
      return {h[127:48], 3'b000, t, h[39:0]};
   endfunction

   task automatic pushHdr(input logic [HW-1:0] h);
      fifoMem[wrPtr[5:0]] = h;
      wrPtr = wrPtr + 1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.tag_free_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitAllocs(input int target, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (allocCount >= target) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic waitValid(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.tlp_hdr_valid === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.tlp_hdr_ready  = 1'b0;
      bus.tag_free_valid = 1'b0;
      bus.tag_free       = '0;
      repeat (3) @(negedge clk);
      checks++; if (bus.tlp_hdr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.tlp_hdr_valid); end
      checks++; if (bus.ar_fifo_rden !== 1'b0) begin errors++; $display("[TB] FAIL reset_rden: got %b expected 0", bus.ar_fifo_rden); end
      checks++; if (bus.tlp_hdr !== '0) begin errors++; $display("[TB] FAIL reset_hdr: got %h expected 0", bus.tlp_hdr); end
      checks++; if (bus.tag_alloc_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_alloc_valid: got %b expected 0", bus.tag_alloc_valid); end
      checks++; if (bus.tag_alloc !== '0) begin errors++; $display("[TB] FAIL reset_alloc: got %h expected 0", bus.tag_alloc); end
      checks++; if (bus.tag_alloc_len !== '0) begin errors++; $display("[TB] FAIL reset_alloc_len: got %h expected 0", bus.tag_alloc_len); end
      checks++; if (outstanding !== '0) begin errors++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
      checks++; if (tagErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_tag_err: got %b expected 0", tagErr); end
      rst = 1'b0;
   endtask

   task automatic test_single_header();
      logic [HW-1:0] h;
      int rd0;
      int al0;
      h   = 128'h1111_2222_3333_4444_5555_AB66_7777_0008;
      rd0 = rdenCount;
      al0 = allocCount;
      bus.tlp_hdr_ready = 1'b1;
      pushHdr(h);
      #1;
      checks++; if (bus.ar_fifo_rden !== 1'b1) begin errors++; $display("[TB] FAIL single_rden: got %b expected 1", bus.ar_fifo_rden); end
      @(negedge clk);
      checks++; if (bus.tlp_hdr_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_load_valid: got %b expected 0", bus.tlp_hdr_valid); end
      @(negedge clk);
      checks++; if (bus.tlp_hdr_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_send_valid: got %b expected 1", bus.tlp_hdr_valid); end
      checks++; if (bus.tlp_hdr !== 128'h1111_2222_3333_4444_5555_0066_7777_0008) begin errors++; $display("[TB] FAIL single_hdr: got %h expected %h", bus.tlp_hdr, 128'h1111_2222_3333_4444_5555_0066_7777_0008); end
      @(negedge clk);
      checks++; if (bus.tag_alloc_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_alloc_valid: got %b expected 1", bus.tag_alloc_valid); end
      checks++; if (bus.tag_alloc !== 5'd0) begin errors++; $display("[TB] FAIL single_alloc_tag: got %0d expected 0", bus.tag_alloc); end
      checks++; if (bus.tag_alloc_len !== 10'd8) begin errors++; $display("[TB] FAIL single_alloc_len: got %0d expected 8", bus.tag_alloc_len); end
      checks++; if (outstanding !== 6'd1) begin errors++; $display("[TB] FAIL single_outstanding: got %0d expected 1", outstanding); end
      checks++; if (bus.tlp_hdr_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_valid: got %b expected 0", bus.tlp_hdr_valid); end
      @(negedge clk);
      checks++; if (bus.tag_alloc_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_len: got %b expected 0", bus.tag_alloc_valid); end
      checks++; if (rdenCount - rd0 !== 1) begin errors++; $display("[TB] FAIL single_rden_count: got %0d expected 1", rdenCount - rd0); end
      checks++; if (allocCount - al0 !== 1) begin errors++; $display("[TB] FAIL single_alloc_count: got %0d expected 1", allocCount - al0); end
   endtask

   task automatic test_exhaustion();
      int base;
      int sBase;
      bit ok;
      doReset();
      base  = allocCount;
      sBase = sentCount;
      bus.tlp_hdr_ready = 1'b1;
      for (int k = 0; k < 33; k++) pushHdr(mkHdr(k));
      waitAllocs(base + 32, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL exh_timeout: got %0d allocs expected 32", allocCount - base); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (bus.ar_fifo_rden !== 1'b0) begin errors++; $display("[TB] FAIL exh_rden_held: got %b expected 0", bus.ar_fifo_rden); end
      end
      for (int k = 0; k < 32; k++) begin
         checks++; if (allocTag[base + k] !== TW'(k)) begin errors++; $display("[TB] FAIL exh_tag[%0d]: got %0d expected %0d", k, allocTag[base + k], k); end
         checks++; if (allocLen[base + k] !== 10'(k + 1)) begin errors++; $display("[TB] FAIL exh_len[%0d]: got %0d expected %0d", k, allocLen[base + k], k + 1); end
         checks++; if (sentHdr[sBase + k] !== expHdr(mkHdr(k), TW'(k))) begin errors++; $display("[TB] FAIL exh_hdr[%0d]: got %h expected %h", k, sentHdr[sBase + k], expHdr(mkHdr(k), TW'(k))); end
      end
      checks++; if (outstanding !== 6'd32) begin errors++; $display("[TB] FAIL exh_outstanding: got %0d expected 32", outstanding); end
      checks++; if (wrPtr - rdPtr !== 1) begin errors++; $display("[TB] FAIL exh_fifo_level: got %0d expected 1", wrPtr - rdPtr); end
      checks++; if (allocCount - base !== 32) begin errors++; $display("[TB] FAIL exh_alloc_count: got %0d expected 32", allocCount - base); end
      bus.tag_free_valid = 1'b1;
      bus.tag_free       = 5'd7;
      @(negedge clk);
      bus.tag_free_valid = 1'b0;
      #1;
      checks++; if (bus.ar_fifo_rden !== 1'b1) begin errors++; $display("[TB] FAIL exh_resume_rden: got %b expected 1", bus.ar_fifo_rden); end
      checks++; if (outstanding !== 6'd31) begin errors++; $display("[TB] FAIL exh_release_outstanding: got %0d expected 31", outstanding); end
      waitAllocs(base + 33, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL exh_resume_timeout: got %0d allocs expected 33", allocCount - base); end
      checks++; if (allocTag[base + 32] !== 5'd7) begin errors++; $display("[TB] FAIL exh_resume_tag: got %0d expected 7", allocTag[base + 32]); end
      checks++; if (sentHdr[sBase + 32] !== expHdr(mkHdr(32), 5'd7)) begin errors++; $display("[TB] FAIL exh_resume_hdr: got %h expected %h", sentHdr[sBase + 32], expHdr(mkHdr(32), 5'd7)); end
      checks++; if (outstanding !== 6'd32) begin errors++; $display("[TB] FAIL exh_final_outstanding: got %0d expected 32", outstanding); end
   endtask

   task automatic test_simultaneous();
      int base;
      bit ok;
      doReset();
      base = allocCount;
      bus.tlp_hdr_ready = 1'b1;
      for (int k = 0; k < 31; k++) pushHdr(mkHdr(k));
      waitAllocs(base + 31, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sim_fill_timeout: got %0d allocs expected 31", allocCount - base); end
      repeat (3) @(negedge clk);
      checks++; if (outstanding !== 6'd31) begin errors++; $display("[TB] FAIL sim_pre_outstanding: got %0d expected 31", outstanding); end
      pushHdr(mkHdr(40));
      bus.tag_free_valid = 1'b1;
      bus.tag_free       = 5'd3;
      #1;
      checks++; if (bus.ar_fifo_rden !== 1'b1) begin errors++; $display("[TB] FAIL sim_rden: got %b expected 1", bus.ar_fifo_rden); end
      @(negedge clk);
      bus.tag_free_valid = 1'b0;
      checks++; if (outstanding !== 6'd31) begin errors++; $display("[TB] FAIL sim_outstanding: got %0d expected 31", outstanding); end
      waitAllocs(base + 32, ok);
      checks++; if (allocTag[base + 31] !== 5'd31) begin errors++; $display("[TB] FAIL sim_tag31: got %0d expected 31", allocTag[base + 31]); end
      pushHdr(mkHdr(41));
      waitAllocs(base + 33, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sim_next_timeout: got %0d allocs expected 33", allocCount - base); end
      checks++; if (allocTag[base + 32] !== 5'd3) begin errors++; $display("[TB] FAIL sim_next_tag: got %0d expected 3", allocTag[base + 32]); end
      checks++; if (outstanding !== 6'd32) begin errors++; $display("[TB] FAIL sim_final_outstanding: got %0d expected 32", outstanding); end
   endtask

   task automatic test_backpressure();
      int base;
      bit ok;
      logic [HW-1:0] exp;
      doReset();
      base = allocCount;
      bus.tlp_hdr_ready = 1'b0;
      pushHdr(mkHdr(50));
      exp = expHdr(mkHdr(50), 5'd0);
      waitValid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_timeout: got %b expected 1", bus.tlp_hdr_valid); end
      for (int c = 0; c < 10; c++) begin
         checks++; if (bus.tlp_hdr_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", c, bus.tlp_hdr_valid); end
         checks++; if (bus.tlp_hdr !== exp) begin errors++; $display("[TB] FAIL bp_hdr[%0d]: got %h expected %h", c, bus.tlp_hdr, exp); end
         checks++; if (bus.tag_alloc_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_alloc[%0d]: got %b expected 0", c, bus.tag_alloc_valid); end
         @(negedge clk);
      end
      bus.tlp_hdr_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.tag_alloc_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_alloc_pulse: got %b expected 1", bus.tag_alloc_valid); end
      checks++; if (bus.tag_alloc !== 5'd0) begin errors++; $display("[TB] FAIL bp_alloc_tag: got %0d expected 0", bus.tag_alloc); end
      checks++; if (bus.tlp_hdr_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop: got %b expected 0", bus.tlp_hdr_valid); end
      @(negedge clk);
      checks++; if (allocCount - base !== 1) begin errors++; $display("[TB] FAIL bp_alloc_count: got %0d expected 1", allocCount - base); end
   endtask

   task automatic test_bad_release();
      bus.tag_free_valid = 1'b1;
      bus.tag_free       = 5'd12;
      @(negedge clk);
      bus.tag_free_valid = 1'b0;
      checks++; if (tagErr !== 1'b1) begin errors++; $display("[TB] FAIL bad_tag_err: got %b expected 1", tagErr); end
      checks++; if (outstanding !== 6'd1) begin errors++; $display("[TB] FAIL bad_outstanding: got %0d expected 1", outstanding); end
      repeat (3) @(negedge clk);
      checks++; if (tagErr !== 1'b1) begin errors++; $display("[TB] FAIL bad_sticky: got %b expected 1", tagErr); end
      bus.tag_free_valid = 1'b1;
      bus.tag_free       = 5'd0;
      @(negedge clk);
      bus.tag_free_valid = 1'b0;
      checks++; if (outstanding !== 6'd0) begin errors++; $display("[TB] FAIL bad_good_release: got %0d expected 0", outstanding); end
      checks++; if (tagErr !== 1'b1) begin errors++; $display("[TB] FAIL bad_sticky_after: got %b expected 1", tagErr); end
   endtask

   task automatic test_reset_mid_send();
      int base;
      bit ok;
      bus.tlp_hdr_ready = 1'b0;
      pushHdr(mkHdr(60));
      waitValid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rms_valid_timeout: got %b expected 1", bus.tlp_hdr_valid); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.tlp_hdr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rms_valid: got %b expected 0", bus.tlp_hdr_valid); end
      checks++; if (outstanding !== 6'd0) begin errors++; $display("[TB] FAIL rms_outstanding: got %0d expected 0", outstanding); end
      checks++; if (tagErr !== 1'b0) begin errors++; $display("[TB] FAIL rms_tag_err: got %b expected 0", tagErr); end
      rst = 1'b0;
      base = allocCount;
      bus.tlp_hdr_ready = 1'b1;
      pushHdr(mkHdr(61));
      waitAllocs(base + 1, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rms_next_timeout: got %0d allocs expected 1", allocCount - base); end
      checks++; if (allocTag[base] !== 5'd0) begin errors++; $display("[TB] FAIL rms_next_tag: got %0d expected 0", allocTag[base]); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_header();
      test_exhaustion();
      test_simultaneous();
      test_backpressure();
      test_bad_release();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
